// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode encodings, pipeline stage indices and flush FSM state type
package lc3b_types;

    typedef logic [3:0] lc3b_opcode;

    localparam lc3b_opcode op_br   = 4'b0000;
    localparam lc3b_opcode op_add  = 4'b0001;
    localparam lc3b_opcode op_ldb  = 4'b0010;
    localparam lc3b_opcode op_stb  = 4'b0011;
    localparam lc3b_opcode op_jsr  = 4'b0100;
    localparam lc3b_opcode op_and  = 4'b0101;
    localparam lc3b_opcode op_ldw  = 4'b0110;
    localparam lc3b_opcode op_stw  = 4'b0111;
    localparam lc3b_opcode op_rti  = 4'b1000;
    localparam lc3b_opcode op_xor  = 4'b1001;
    localparam lc3b_opcode op_jmp  = 4'b1100;
    localparam lc3b_opcode op_shf  = 4'b1101;
    localparam lc3b_opcode op_lea  = 4'b1110;
    localparam lc3b_opcode op_trap = 4'b1111;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;
    localparam int NUM_PIPE_STAGES = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SQUASH = 2'd2
    } flush_state_t;

endpackage

// File: rtl/flush_event_decode.sv
// rtl/flush_event_decode.sv - combinational detection of control-flow redirects and their squash masks
module flush_event_decode
    import lc3b_types::*;
#(
    parameter int NUM_STAGES = NUM_PIPE_STAGES,
    parameter int EX_STAGE   = STAGE_EX,
    parameter int MEM_STAGE  = STAGE_MEM
) (
    input  logic [3:0]            i_ex_opcode,
    input  logic                  i_ex_valid,
    input  logic [3:0]            i_mem_opcode,
    input  logic                  i_mem_valid,
    input  logic                  i_branch_enable,
    output logic                  o_mem_event,
    output logic                  o_event,
    output logic [NUM_STAGES-1:0] o_mask,
    output logic [NUM_STAGES-1:0] o_mem_mask
);

    // Each resolving stage squashes only the younger stages in front of it.
    localparam logic [NUM_STAGES-1:0] EX_MASK  = NUM_STAGES'((1 << EX_STAGE) - 1);
    localparam logic [NUM_STAGES-1:0] MEM_MASK = NUM_STAGES'((1 << MEM_STAGE) - 1);

    logic w_ex_event;

    always_comb begin
        w_ex_event = 1'b0;
        if (i_ex_valid) begin
            case (i_ex_opcode)
                op_br:          w_ex_event = i_branch_enable;
                op_jmp, op_jsr: w_ex_event = 1'b1;
                default:        w_ex_event = 1'b0;
            endcase
        end
    end

    assign o_mem_event = i_mem_valid && (i_mem_opcode == op_trap);
    assign o_event     = o_mem_event || w_ex_event;
    // The trap is the older instruction, so it wins over a simultaneous EX redirect.
    assign o_mask      = o_mem_event ? MEM_MASK : (w_ex_event ? EX_MASK : '0);
    assign o_mem_mask  = MEM_MASK;

endmodule

// File: rtl/flush_ctrl.sv
// rtl/flush_ctrl.sv - pipeline flush controller with stall-aware pending and multi-cycle squash
module flush_ctrl
    import lc3b_types::*;
#(
    parameter int NUM_STAGES    = NUM_PIPE_STAGES,
    parameter int EX_STAGE      = STAGE_EX,
    parameter int MEM_STAGE     = STAGE_MEM,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            ex_opcode,
    input  logic                  ex_valid,
    input  logic [3:0]            mem_opcode,
    input  logic                  mem_valid,
    input  logic                  branch_enable,
    input  logic                  stall,
    output logic [NUM_STAGES-1:0] flush_mask,
    output logic                  flush,
    output logic                  flush_pending,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [3:0] CNT_LOAD = 4'(SQUASH_CYCLES - 1);
    localparam logic [3:0] CNT_FULL = 4'(SQUASH_CYCLES);
    localparam bit         MULTI    = (SQUASH_CYCLES > 1);

    flush_state_t          r_state;
    logic [NUM_STAGES-1:0] r_mask;
    logic [NUM_STAGES-1:0] r_pend_mask;
    logic [3:0]            r_cnt;
    logic [CNT_W-1:0]      r_count;

    flush_state_t          w_state_next;
    logic [NUM_STAGES-1:0] w_mask_next;
    logic [NUM_STAGES-1:0] w_pend_next;
    logic [3:0]            w_cnt_next;
    logic                  w_accept;
    logic [NUM_STAGES-1:0] w_flush_mask;
    logic [NUM_STAGES-1:0] w_sel;

    logic                  w_mem_event;
    logic                  w_event;
    logic [NUM_STAGES-1:0] w_ev_mask;
    logic [NUM_STAGES-1:0] w_mem_mask;

    flush_event_decode #(
        .NUM_STAGES (NUM_STAGES),
        .EX_STAGE   (EX_STAGE),
        .MEM_STAGE  (MEM_STAGE)
    ) u_decode (
        .i_ex_opcode     (ex_opcode),
        .i_ex_valid      (ex_valid),
        .i_mem_opcode    (mem_opcode),
        .i_mem_valid     (mem_valid),
        .i_branch_enable (branch_enable),
        .o_mem_event     (w_mem_event),
        .o_event         (w_event),
        .o_mask          (w_ev_mask),
        .o_mem_mask      (w_mem_mask)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_pend_mask <= '0;
            r_cnt       <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mask      <= w_mask_next;
            r_pend_mask <= w_pend_next;
            r_cnt       <= w_cnt_next;
            if (w_accept && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_pend_next  = r_pend_mask;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_flush_mask = '0;
        w_sel        = r_pend_mask;

        case (r_state)
            IDLE: begin
                if (w_event) begin
                    w_accept = 1'b1;
                    if (!stall) begin
                        w_flush_mask = w_ev_mask;
                        if (MULTI) begin
                            w_state_next = SQUASH;
                            w_mask_next  = w_ev_mask;
                            w_cnt_next   = CNT_LOAD;
                        end
                    end else begin
                        w_state_next = PEND;
                        w_pend_next  = w_ev_mask;
                    end
                end
            end

            PEND: begin
                // Only a trap can widen a pending flush; EX events are already in its shadow.
                if (w_mem_event && ((w_mem_mask & ~r_pend_mask) != '0)) begin
                    w_sel    = w_mem_mask;
                    w_accept = 1'b1;
                end
                if (stall) begin
                    w_pend_next = w_sel;
                end else begin
                    w_flush_mask = w_sel;
                    w_pend_next  = '0;
                    if (MULTI) begin
                        w_state_next = SQUASH;
                        w_mask_next  = w_sel;
                        w_cnt_next   = CNT_LOAD;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end

            SQUASH: begin
                w_flush_mask = r_mask;
                if (w_mem_event && ((w_mem_mask & ~r_mask) != '0)) begin
                    w_accept    = 1'b1;
                    w_mask_next = w_mem_mask;
                    if (stall) begin
                        // Output holds while frozen; the full unstalled budget is still owed.
                        w_cnt_next = CNT_FULL;
                    end else begin
                        w_flush_mask = w_mem_mask;
                        if (MULTI) begin
                            w_cnt_next = CNT_LOAD;
                        end else begin
                            w_state_next = IDLE;
                            w_mask_next  = '0;
                            w_cnt_next   = '0;
                        end
                    end
                end else if (!stall) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_next = IDLE;
                        w_mask_next  = '0;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_mask_next  = '0;
                w_pend_next  = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign flush_mask    = reset_n ? w_flush_mask : '0;
    assign flush         = |flush_mask;
    assign flush_pending = (r_state == PEND);
    assign flush_count   = r_count;

endmodule

// File: tb/tb_flush_ctrl.sv
// tb/tb_flush_ctrl.sv - directed table-driven bench for flush_ctrl
module tb_flush_ctrl;
    import lc3b_types::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  ex_opcode;
    logic        ex_valid;
    logic [3:0]  mem_opcode;
    logic        mem_valid;
    logic        branch_enable;
    logic        stall;
    logic [4:0]  flush_mask;
    logic        flush;
    logic        flush_pending;
    logic [15:0] flush_count;
    logic [4:0]  flush_mask2;
    logic        flush2;
    logic        flush_pending2;
    logic [1:0]  flush_count2;

    int n_checks = 0;
    int n_fail   = 0;

    flush_ctrl u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_opcode     (ex_opcode),
        .ex_valid      (ex_valid),
        .mem_opcode    (mem_opcode),
        .mem_valid     (mem_valid),
        .branch_enable (branch_enable),
        .stall         (stall),
        .flush_mask    (flush_mask),
        .flush         (flush),
        .flush_pending (flush_pending),
        .flush_count   (flush_count)
    );

    flush_ctrl #(.SQUASH_CYCLES(1), .CNT_W(2)) u_dut2 (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_opcode     (ex_opcode),
        .ex_valid      (ex_valid),
        .mem_opcode    (mem_opcode),
        .mem_valid     (mem_valid),
        .branch_enable (branch_enable),
        .stall         (stall),
        .flush_mask    (flush_mask2),
        .flush         (flush2),
        .flush_pending (flush_pending2),
        .flush_count   (flush_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] eo;
        logic       ev;
        logic [3:0] mo;
        logic       mv;
        logic       be;
        logic       st;
        logic [4:0] mask;
        logic       pend;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] eo, input logic ev, input logic [3:0] mo, input logic mv,
                       input logic be, input logic st, input logic [4:0] mask, input logic pend,
                       input int cnt);
        vec_t v;
        v.eo = eo; v.ev = ev; v.mo = mo; v.mv = mv; v.be = be; v.st = st;
        v.mask = mask; v.pend = pend; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] eo, input logic ev, input logic [3:0] mo, input logic mv,
                         input logic be, input logic st);
        ex_opcode = eo; ex_valid = ev; mem_opcode = mo; mem_valid = mv;
        branch_enable = be; stall = st;
    endtask

    task automatic nop_cycle(input logic st);
        @(negedge clk);
        drive(op_add, 1'b1, op_add, 1'b1, 1'b0, st);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(op_add, 1'b0, op_add, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_mask", int'(flush_mask), 0);
        check("reset_flush", int'(flush), 0);
        check("reset_pending", int'(flush_pending), 0);
        check("reset_count", int'(flush_count), 0);
        reset_n = 1'b1;

        // taken br, not-taken br, invalid jmp
        add(op_br,  1, op_add, 1, 1, 0, 5'b00011, 0, 0);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00011, 0, 1);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00000, 0, 1);
        add(op_br,  1, op_add, 1, 0, 0, 5'b00000, 0, 1);
        add(op_jmp, 0, op_add, 1, 0, 0, 5'b00000, 0, 1);
        // trap and jmp together
        add(op_jmp, 1, op_trap, 1, 0, 0, 5'b00111, 0, 1);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00111, 0, 2);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00000, 0, 2);
        // jsr held pending under a 3-cycle stall
        add(op_jsr, 1, op_add, 1, 0, 1, 5'b00000, 0, 2);
        add(op_add, 1, op_add, 1, 0, 1, 5'b00000, 1, 3);
        add(op_add, 1, op_add, 1, 0, 1, 5'b00000, 1, 3);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00011, 1, 3);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00011, 0, 3);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00000, 0, 3);
        // stall in the middle of a squash
        add(op_br,  1, op_add, 1, 1, 0, 5'b00011, 0, 3);
        add(op_add, 1, op_add, 1, 0, 1, 5'b00011, 0, 4);
        add(op_add, 1, op_add, 1, 0, 1, 5'b00011, 0, 4);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00011, 0, 4);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00000, 0, 4);
        // trap widens a running br squash
        add(op_br,  1, op_add,  1, 1, 0, 5'b00011, 0, 4);
        add(op_add, 1, op_trap, 1, 0, 0, 5'b00111, 0, 5);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00111, 0, 6);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00000, 0, 6);
        // trap replaces a pending jmp, later jsr ignored
        add(op_jmp, 1, op_add,  1, 0, 1, 5'b00000, 0, 6);
        add(op_add, 1, op_trap, 1, 0, 1, 5'b00000, 1, 7);
        add(op_jsr, 1, op_add,  1, 0, 1, 5'b00000, 1, 8);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00111, 1, 8);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00111, 0, 8);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00000, 0, 8);
        // EX event during squash is ignored
        add(op_jsr, 1, op_add, 1, 0, 0, 5'b00011, 0, 8);
        add(op_jmp, 1, op_add, 1, 0, 0, 5'b00011, 0, 9);
        add(op_add, 1, op_add, 1, 0, 0, 5'b00000, 0, 9);
        // trap during trap squash is not wider, so ignored
        add(op_add, 1, op_trap, 1, 0, 0, 5'b00111, 0, 9);
        add(op_add, 1, op_trap, 1, 0, 0, 5'b00111, 0, 10);
        add(op_add, 1, op_add,  1, 0, 0, 5'b00000, 0, 10);
        add(op_add, 1, op_trap, 0, 0, 0, 5'b00000, 0, 10);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].eo, vecs[i].ev, vecs[i].mo, vecs[i].mv, vecs[i].be, vecs[i].st);
            #1;
            check($sformatf("vec%0d_mask", i), int'(flush_mask), int'(vecs[i].mask));
            check($sformatf("vec%0d_flush", i), int'(flush), int'(|vecs[i].mask));
            check($sformatf("vec%0d_pending", i), int'(flush_pending), int'(vecs[i].pend));
            check($sformatf("vec%0d_count", i), int'(flush_count), vecs[i].cnt);
        end

        // reset in the middle of a squash
        @(negedge clk);
        drive(op_br, 1'b1, op_add, 1'b1, 1'b1, 1'b0);
        #1;
        check("rst_sq_pre_mask", int'(flush_mask), 5'b00011);
        nop_cycle(1'b0);
        check("rst_sq_mid_mask", int'(flush_mask), 5'b00011);
        #1 reset_n = 1'b0;
        #1;
        check("rst_sq_mask", int'(flush_mask), 0);
        check("rst_sq_flush", int'(flush), 0);
        check("rst_sq_pending", int'(flush_pending), 0);
        check("rst_sq_count", int'(flush_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nop_cycle(1'b0);
            check($sformatf("rst_sq_after%0d", i), int'(flush), 0);
        end

        // reset while a flush is pending
        @(negedge clk);
        drive(op_jsr, 1'b1, op_add, 1'b1, 1'b0, 1'b1);
        #1;
        check("rst_pd_pre_flush", int'(flush), 0);
        nop_cycle(1'b1);
        check("rst_pd_mid_pending", int'(flush_pending), 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_pd_pending", int'(flush_pending), 0);
        check("rst_pd_count", int'(flush_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nop_cycle(1'b0);
            check($sformatf("rst_pd_after%0d", i), int'(flush), 0);
            check($sformatf("rst_pd_after_pend%0d", i), int'(flush_pending), 0);
        end

        // single-cycle squash and counter saturation on the narrow instance
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(op_br, 1'b1, op_add, 1'b1, 1'b1, 1'b0);
            #1;
            check($sformatf("sat_mask%0d", i), int'(flush_mask2), 5'b00011);
            check($sformatf("sat_count%0d", i), int'(flush_count2), i);
        end
        nop_cycle(1'b0);
        check("sat_final_mask", int'(flush_mask2), 0);
        check("sat_final_count", int'(flush_count2), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
